// File: rtl/icache_linefill_ctrl_pkg.sv
// Shared types and constants for the icache refill return path.
// Line geometry, the per-miss request record and the linefill FSM states.
package icache_linefill_ctrl_pkg;

  localparam int ENTRY_NUM            = 8;
  localparam int ENTRY_IDX_W          = 3;
  localparam int ICACHE_LINE_BEAT_NUM = 4;
  localparam int ICACHE_BEAT_WIDTH    = 128;
  localparam int INDEX_W              = 7;
  localparam int BEAT_CNT_W           = $clog2(ICACHE_LINE_BEAT_NUM);
  localparam int LINE_W               = ICACHE_LINE_BEAT_NUM * ICACHE_BEAT_WIDTH;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic               way;
  } linefill_req_info_t;

  typedef enum logic [1:0] {
    LF_IDLE    = 2'd0,
    LF_COLLECT = 2'd1,
    LF_WRITE   = 2'd2,
    LF_DONE    = 2'd3
  } linefill_state_e;

  // True when the beat counter points at the final slot of a line.
  function automatic logic is_last_slot(input logic [BEAT_CNT_W-1:0] cnt);
    return cnt == BEAT_CNT_W'(ICACHE_LINE_BEAT_NUM - 1);
  endfunction

endpackage

// File: rtl/icache_linefill_ctrl_if.sv
// Bus bundle between the MSHR file / downstream response channel / dataram
// and the linefill controller, plus the controller's debug view.
interface icache_linefill_ctrl_if;
  import icache_linefill_ctrl_pkg::*;

  // Handshakes (rxdat, dataram_wr): a transfer happens in a cycle where both
  // vld and rdy are high; once vld is raised the payload stays stable and vld
  // stays high until that transfer. txreq_fire is an already-completed transfer.
  logic                       txreq_fire;
  logic [ENTRY_IDX_W-1:0]     txreq_entry_id;
  logic [INDEX_W-1:0]         txreq_index;
  logic                       txreq_way;

  logic                       rxdat_vld;
  logic                       rxdat_rdy;
  logic [ENTRY_IDX_W-1:0]     rxdat_entry_id;
  logic [ICACHE_BEAT_WIDTH-1:0] rxdat_data;
  logic                       rxdat_last;

  logic                       dataram_wr_vld;
  logic                       dataram_wr_rdy;
  logic [INDEX_W-1:0]         dataram_wr_index;
  logic                       dataram_wr_way;
  logic [LINE_W-1:0]          dataram_wr_data;

  logic                       linefill_done;
  logic [ENTRY_IDX_W:0]       linefill_ack_entry_idx;
  logic                       proto_err;

  linefill_state_e            dbg_state;
  logic [ENTRY_NUM-1:0]       dbg_table_vld;

  modport master (
    output txreq_fire, txreq_entry_id, txreq_index, txreq_way,
    output rxdat_vld, rxdat_entry_id, rxdat_data, rxdat_last,
    input  rxdat_rdy,
    input  dataram_wr_vld, dataram_wr_index, dataram_wr_way, dataram_wr_data,
    output dataram_wr_rdy,
    input  linefill_done, linefill_ack_entry_idx, proto_err,
    input  dbg_state, dbg_table_vld
  );

  modport slave (
    input  txreq_fire, txreq_entry_id, txreq_index, txreq_way,
    input  rxdat_vld, rxdat_entry_id, rxdat_data, rxdat_last,
    output rxdat_rdy,
    output dataram_wr_vld, dataram_wr_index, dataram_wr_way, dataram_wr_data,
    input  dataram_wr_rdy,
    output linefill_done, linefill_ack_entry_idx, proto_err,
    output dbg_state, dbg_table_vld
  );

endinterface

// File: rtl/icache_linefill_ctrl_req_table.sv
// Per-MSHR-entry record of outstanding miss requests {vld, index, way}.
// A set and a clear of the same entry in one cycle leaves the entry valid.
module linefill_req_table
  import icache_linefill_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   set_en,
  input  logic [ENTRY_IDX_W-1:0] set_id,
  input  linefill_req_info_t     set_info,
  output logic                   set_hit,
  input  logic                   clr_en,
  input  logic [ENTRY_IDX_W-1:0] clr_id,
  input  logic [ENTRY_IDX_W-1:0] lkup_id,
  output logic                   lkup_vld,
  output linefill_req_info_t     lkup_info,
  output logic [ENTRY_NUM-1:0]   vld_vec
);

  logic [ENTRY_NUM-1:0] vld_q;
  linefill_req_info_t   info_q [ENTRY_NUM];

  // The set is written after the clear so it takes priority on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      if (clr_en) vld_q[clr_id] <= 1'b0;
      if (set_en) vld_q[set_id] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (set_en) info_q[set_id] <= set_info;
  end

  assign set_hit   = vld_q[set_id];
  assign lkup_vld  = vld_q[lkup_id];
  assign lkup_info = info_q[lkup_id];
  assign vld_vec   = vld_q;

endmodule

// File: rtl/icache_linefill_ctrl.sv
// Collects refill beats for one icache line, writes the whole line into the
// dataram, then acknowledges the owning MSHR entry.
module icache_linefill_ctrl
  import icache_linefill_ctrl_pkg::*;
(
  input logic                   clk,
  input logic                   rst_n,
  icache_linefill_ctrl_if.slave lf
);

  linefill_state_e state_q, state_d;

  logic [BEAT_CNT_W-1:0]  cnt_q;
  logic [ENTRY_IDX_W-1:0] cur_id_q;
  linefill_req_info_t     cur_info_q;
  logic [ICACHE_LINE_BEAT_NUM-1:0][ICACHE_BEAT_WIDTH-1:0] line_q;
  logic                   proto_err_q;

  logic                   rx_open;
  logic                   beat_fire;
  logic                   set_hit;
  logic                   lkup_vld;
  linefill_req_info_t     lkup_info;
  linefill_req_info_t     set_info;
  logic                   err_now;

  assign set_info = '{index: lf.txreq_index, way: lf.txreq_way};

  linefill_req_table u_req_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (lf.txreq_fire),
    .set_id    (lf.txreq_entry_id),
    .set_info  (set_info),
    .set_hit   (set_hit),
    .clr_en    (state_q == LF_DONE),
    .clr_id    (cur_id_q),
    .lkup_id   (lf.rxdat_entry_id),
    .lkup_vld  (lkup_vld),
    .lkup_info (lkup_info),
    .vld_vec   (lf.dbg_table_vld)
  );

  assign rx_open   = (state_q == LF_IDLE) || (state_q == LF_COLLECT);
  assign beat_fire = rx_open && lf.rxdat_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LF_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d                   = state_q;
    lf.rxdat_rdy              = 1'b0;
    lf.dataram_wr_vld         = 1'b0;
    lf.linefill_done          = 1'b0;
    lf.linefill_ack_entry_idx = '0;
    case (state_q)
      LF_IDLE: begin
        lf.rxdat_rdy = 1'b1;
        if (beat_fire) state_d = LF_COLLECT;
      end
      LF_COLLECT: begin
        lf.rxdat_rdy = 1'b1;
        if (beat_fire && is_last_slot(cnt_q)) state_d = LF_WRITE;
      end
      LF_WRITE: begin
        lf.dataram_wr_vld = 1'b1;
        if (lf.dataram_wr_rdy) state_d = LF_DONE;
      end
      LF_DONE: begin
        lf.linefill_done          = 1'b1;
        lf.linefill_ack_entry_idx = {1'b0, cur_id_q};
        state_d                   = LF_IDLE;
      end
      default: state_d = LF_IDLE;
    endcase
  end

  // Protocol violations are flagged but never change how the line completes.
  always_comb begin
    err_now = 1'b0;
    if (lf.txreq_fire && set_hit) err_now = 1'b1;
    if (beat_fire) begin
      if (lf.rxdat_last != is_last_slot(cnt_q)) err_now = 1'b1;
      if (state_q == LF_IDLE && !lkup_vld) err_now = 1'b1;
      if (state_q == LF_COLLECT && lf.rxdat_entry_id != cur_id_q) err_now = 1'b1;
    end
  end

  // cnt_q is 0 in IDLE, so the first beat lands in slot 0; the counter wraps
  // back to 0 on the beat that completes the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      cur_id_q    <= '0;
      cur_info_q  <= '0;
      line_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (beat_fire) begin
        line_q[cnt_q] <= lf.rxdat_data;
        cnt_q         <= cnt_q + 1'b1;
      end
      if (state_q == LF_IDLE && beat_fire) begin
        cur_id_q   <= lf.rxdat_entry_id;
        cur_info_q <= lkup_vld ? lkup_info : '0;
      end
      proto_err_q <= proto_err_q | err_now;
    end
  end

  assign lf.dataram_wr_index = cur_info_q.index;
  assign lf.dataram_wr_way   = cur_info_q.way;
  assign lf.dataram_wr_data  = line_q;
  assign lf.proto_err        = proto_err_q;
  assign lf.dbg_state        = state_q;

endmodule
